// File: rtl/pll_rst_ctrl.sv
// Reset sequencer for the board PLL: pulses the PLL reset, qualifies a synchronised
// lock flag and releases the system reset once lock has been stable long enough.
module pll_rst_ctrl #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int RELOCK_W         = 8
) (
    input  logic                clkin1,
    input  logic                ext_rst,
    input  logic                pll_lock,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                lock_ok,
    output logic [RELOCK_W-1:0] relock_cnt
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               lock_meta_r;
    logic               lock_s;
    logic               relock_inc_s;

    // The event counter sticks at all-ones so a flapping PLL never appears healthy.
    function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + RELOCK_W'(1);
        end
    endfunction

    // Two-flop synchroniser bringing the PLL lock flag into the clkin1 domain.
    always_ff @(posedge clkin1) begin
        if (ext_rst) begin
            lock_meta_r <= 1'b0;
            lock_s      <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_s      <= lock_meta_r;
        end
    end

    // Next-state decision; a lock seen on the timeout cycle wins, a drop on the stable cycle wins.
    always_comb begin
        state_nxt_s  = state_r;
        relock_inc_s = 1'b0;
        case (state_r)
            ST_PLL_RST: begin
                if (cnt_r == PULSE_LAST) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else begin
                    state_nxt_s = ST_PLL_RST;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt_s = ST_STABLE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s  = ST_PLL_RST;
                    relock_inc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STABLE;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt_s  = ST_PLL_RST;
                    relock_inc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_PLL_RST;
            end
        endcase
    end

    // State, shared counter and outputs, all decoded from the next state so they move together.
    always_ff @(posedge clkin1) begin
        if (ext_rst) begin
            state_r    <= ST_PLL_RST;
            cnt_r      <= {CNT_W{1'b0}};
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            lock_ok    <= 1'b0;
            relock_cnt <= {RELOCK_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r != ST_RUN) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            pll_rst <= (state_nxt_s == ST_PLL_RST);
            sys_rst <= (state_nxt_s != ST_RUN);
            lock_ok <= (state_nxt_s == ST_RUN);
            if (relock_inc_s) begin
                relock_cnt <= sat_inc(relock_cnt);
            end else begin
                relock_cnt <= relock_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Bench for pll_rst_ctrl: directed sequences plus random lock/reset traffic,
// every cycle compared against a remaining-time reference model.
module tb_pll_rst_ctrl;

    localparam int RP  = 4;
    localparam int TO  = 32;
    localparam int ST  = 8;
    localparam int RW  = 8;
    localparam int SAT = (1 << RW) - 1;

    localparam int M_PULSE  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STABLE = 2;
    localparam int M_RUN    = 3;

    logic          clkin1 = 1'b0;
    logic          ext_rst = 1'b1;
    logic          pll_lock = 1'b0;
    logic          pll_rst;
    logic          sys_rst;
    logic          lock_ok;
    logic [RW-1:0] relock_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode   = M_PULSE;
    int m_left   = RP;
    int m_relock = 0;
    bit m_sync0  = 1'b0;
    bit m_sync1  = 1'b0;
    bit m_valid  = 1'b0;

    pll_rst_ctrl #(
        .RST_PULSE_CYC   (RP),
        .LOCK_TIMEOUT_CYC(TO),
        .LOCK_STABLE_CYC (ST),
        .RELOCK_W        (RW)
    ) dut (
        .clkin1    (clkin1),
        .ext_rst   (ext_rst),
        .pll_lock  (pll_lock),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .lock_ok   (lock_ok),
        .relock_cnt(relock_cnt)
    );

    always #10 clkin1 = ~clkin1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each phase tracks how many cycles remain before it expires.
    task automatic model_step();
        bit lk;
        lk = m_sync1;
        if (ext_rst) begin
            m_mode   = M_PULSE;
            m_left   = RP;
            m_relock = 0;
            m_sync0  = 1'b0;
            m_sync1  = 1'b0;
            m_valid  = 1'b1;
        end else begin
            case (m_mode)
                M_PULSE: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = M_WAIT; m_left = TO; end
                end
                M_WAIT: begin
                    if (lk) begin
                        m_mode = M_STABLE; m_left = ST;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_mode = M_PULSE; m_left = RP;
                            if (m_relock < SAT) m_relock++;
                        end
                    end
                end
                M_STABLE: begin
                    if (!lk) begin
                        m_mode = M_WAIT; m_left = TO;
                    end else begin
                        m_left--;
                        if (m_left == 0) m_mode = M_RUN;
                    end
                end
                default: begin
                    if (!lk) begin
                        m_mode = M_PULSE; m_left = RP;
                        if (m_relock < SAT) m_relock++;
                    end
                end
            endcase
            m_sync1 = m_sync0;
            m_sync0 = pll_lock;
        end
    endtask

    task automatic cycle(input logic rst, input logic lk);
        logic [10:0] exp;
        @(negedge clkin1);
        ext_rst  = rst;
        pll_lock = lk;
        @(posedge clkin1);
        model_step();
        #1;
        if (m_valid) begin
            exp = {m_mode == M_PULSE, m_mode != M_RUN, m_mode == M_RUN, m_relock[RW-1:0]};
            check("outs", {pll_rst, sys_rst, lock_ok, relock_cnt}, exp);
        end
    endtask

    task automatic run(input int n, input logic lk);
        for (int i = 0; i < n; i++) cycle(1'b0, lk);
    endtask

    // Drive lock high until sys_rst releases; returns edges after the first lock-sampling edge.
    task automatic measure_release(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            cycle(1'b0, 1'b1);
            if (sys_rst == 1'b0) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    // Starting right after a reset edge: pulse width, then lock 10 cycles into WAIT_LOCK.
    task automatic power_up(input string tag);
        int hi;
        int lat;
        hi = int'(pll_rst);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0);
            hi += int'(pll_rst);
        end
        check({tag, "_pulse_w"}, hi, RP);
        run(6, 1'b0);
        measure_release(lat);
        check({tag, "_latency"}, lat, 2 + ST);
        check({tag, "_lock_ok"}, lock_ok, 1'b1);
        check({tag, "_relock"}, relock_cnt, 0);
    endtask

    initial begin
        int lat;
        int hi;
        int last_rise;
        logic prev;

        // Scenario 1: power-up with good lock
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("rst_state", {pll_rst, sys_rst, lock_ok, relock_cnt}, {3'b110, 8'd0});
        power_up("s1");

        // Scenario 4: one-cycle lock loss while running
        run(5, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("s4_still_run", sys_rst, 1'b0);
        cycle(1'b0, 1'b1);
        check("s4_reset", {sys_rst, lock_ok, pll_rst}, 3'b101);
        check("s4_relock", relock_cnt, 1);
        hi = 1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1);
            hi += int'(pll_rst);
        end
        check("s4_pulse_w", hi, RP);
        run(20, 1'b1);
        check("s4_relocked", lock_ok, 1'b1);

        // Scenario 2: no lock at all
        cycle(1'b1, 1'b0);
        prev = pll_rst;
        last_rise = -1;
        for (int i = 1; i <= 200; i++) begin
            cycle(1'b0, 1'b0);
            if (pll_rst && !prev) begin
                if (last_rise >= 0) check("s2_period", i - last_rise, RP + TO);
                last_rise = i;
            end
            prev = pll_rst;
        end
        check("s2_relock", relock_cnt, 5);
        check("s2_sys_rst", sys_rst, 1'b1);

        // Scenario 3: lock glitch during STABLE
        cycle(1'b1, 1'b0);
        run(9, 1'b0);
        run(5, 1'b1);
        cycle(1'b0, 1'b0);
        measure_release(lat);
        check("s3_latency", lat, 2 + ST);
        check("s3_relock", relock_cnt, 0);

        // Scenario 5a: lock arriving around the timeout boundary
        for (int d = 28; d <= 31; d++) begin
            cycle(1'b1, 1'b0);
            run(4, 1'b0);
            run(d - 1, 1'b0);
            run(6, 1'b1);
            check("s5a_relock", relock_cnt, (d == 31) ? 1 : 0);
        end

        // Scenario 5b: saturation of the relock counter
        cycle(1'b1, 1'b0);
        run(260 * (RP + TO), 1'b0);
        check("s5b_sat", relock_cnt, SAT);

        // Scenario 6: mid-operation reset from RUN with three relocks recorded
        cycle(1'b1, 1'b0);
        run(RP + 3 * (RP + TO), 1'b0);
        run(40, 1'b1);
        check("s6_pre_relock", relock_cnt, 3);
        check("s6_pre_run", lock_ok, 1'b1);
        cycle(1'b1, 1'b1);
        check("s6_rst", {sys_rst, pll_rst, relock_cnt}, {2'b11, 8'd0});
        power_up("s6");

        // Random lock segments with occasional resets
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            logic val;
            len = $urandom_range(1, 50);
            val = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++) begin
                cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, val);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
